// File: rtl/vblank_write_queue.sv
// vblank_write_queue: in-order request FIFO that issues CPU reads/writes onto the
// graphics chip-select/write-enable bus, only while the gate (vertical blank) is open.
//
// Optional feature macro: VBLANK_GATE_EN
//   defined   : transactions start only while vblank is high
//   undefined : gate always open, vblank unused, queue drains whenever non-empty
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   vblank              vertical blank level (clk domain)
//   req_valid/req_ready request handshake; req_ready = ~full and low during rst
//   req_write/req_addr/req_data  request fields (data ignored for reads)
//   rsp_valid/rsp_data  one-cycle read-data strobe; rsp_data holds between reads
//   gp_cs_l/gp_we_l/gp_addr/gp_wdata  registered graphics bus outputs
//   gp_rdata            graphics read data, valid one cycle after the read select
//   count               FIFO occupancy
module vblank_write_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblank,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [7:0]             req_data,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   gp_cs_l,
    output logic                   gp_we_l,
    output logic [ADDR_W-1:0]      gp_addr,
    output logic [7:0]             gp_wdata,
    input  logic [7:0]             gp_rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + 9;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

    state_e state_q, state_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [ENT_W-1:0]  head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;
    logic              gate, push, pop, full, empty, issue_start;

    logic              cs_l_q, cs_l_d, we_l_q, we_l_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;

`ifdef VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate = 1'b1;
`endif

    // ---------------- FIFO ----------------
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = ~full & ~rst;
    assign push      = req_valid & req_ready;
    // The head leaves the queue on the edge that ends its select cycle.
    assign pop       = (state_q == StIssue);

    assign head = mem_q[rd_ptr_q];
    assign {head_write, head_addr, head_data} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_write, req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // vblank is only consulted in StIdle; a started transaction always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!empty && gate) state_d = StIssue;
            StIssue:  state_d = head_write ? StIdle : StRdWait;
            StRdWait: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs (next values of the output flops) ----------------
    assign issue_start = (state_q == StIdle) && (state_d == StIssue);

    always_comb begin
        cs_l_d      = 1'b1;
        we_l_d      = 1'b1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        if (issue_start) begin
            cs_l_d  = 1'b0;
            we_l_d  = ~head_write;
            addr_d  = head_addr;
            wdata_d = head_data;
        end
        // gp_rdata is valid during RDWAIT, i.e. one cycle after the select.
        if (state_q == StRdWait) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = gp_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_l_q      <= 1'b1;
            we_l_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            cs_l_q      <= cs_l_d;
            we_l_q      <= we_l_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gp_cs_l   = cs_l_q;
    assign gp_we_l   = we_l_q;
    assign gp_addr   = addr_q;
    assign gp_wdata  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_vblank_write_queue.sv
// Testbench for vblank_write_queue: directed scenarios plus randomized traffic,
// checked against a transaction-level model (request queue, reference RAM,
// spec-level issue/response timing) running on the falling clock edge.
module tb_vblank_write_queue;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int          CW     = $clog2(DEPTH) + 1;
`ifdef VBLANK_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vblank = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_data = '0;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic              gp_cs_l;
    logic              gp_we_l;
    logic [ADDR_W-1:0] gp_addr;
    logic [7:0]        gp_wdata;
    logic [7:0]        gp_rdata = '0;
    logic [CW-1:0]     count;

    int checks = 0;
    int errors = 0;

    vblank_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .vblank    (vblank),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .gp_cs_l   (gp_cs_l),
        .gp_we_l   (gp_we_l),
        .gp_addr   (gp_addr),
        .gp_wdata  (gp_wdata),
        .gp_rdata  (gp_rdata),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    // Graphics-side RAM: data_out is registered on the select cycle, junk otherwise.
    logic [7:0] tb_ram  [0:65535];
    logic [7:0] ref_ram [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_ram[i]  = init_val(16'(i));
            ref_ram[i] = init_val(16'(i));
        end
    end

    always @(posedge clk) begin
        if (gp_cs_l === 1'b0) begin
            gp_rdata <= tb_ram[gp_addr];
            if (gp_we_l === 1'b0) tb_ram[gp_addr] = gp_wdata;
        end else begin
            gp_rdata <= 8'($urandom);
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } req_t;

    req_t       exp_q[$];
    logic [7:0] rsp_exp_q[$];
    logic [7:0] last_rsp  = 8'h00;
    bit         prev_rst  = 1'b1;
    bit         prev_idle = 1'b1;
    bit         prev_gate = 1'b0;
    bit         rd_d1     = 1'b0;
    bit         rd_d2     = 1'b0;
    int         prev_size = 0;

    always @(negedge clk) begin : monitor
        bit   exp_cs;
        bit   issue_rd;
        bit   model_ready;
        req_t e;
        // A select starts one edge after an idle cycle with work queued and the gate open.
        exp_cs = !prev_rst && prev_idle && (prev_size > 0) && prev_gate;
        checks++;
        if (gp_cs_l !== !exp_cs) begin
            errors++;
            $display("FAIL bus_select t=%0t gp_cs_l=%b required %b", $time, gp_cs_l, !exp_cs);
        end
        if (rd_d2 && rsp_exp_q.size() > 0) last_rsp = rsp_exp_q.pop_front();
        checks++;
        if (rsp_valid !== rd_d2) begin
            errors++;
            $display("FAIL rsp_valid t=%0t got %b required %b", $time, rsp_valid, rd_d2);
        end
        checks++;
        if (rsp_data !== last_rsp) begin
            errors++;
            $display("FAIL rsp_data t=%0t got %h required %h", $time, rsp_data, last_rsp);
        end
        checks++;
        if (count !== CW'(exp_q.size())) begin
            errors++;
            $display("FAIL count t=%0t got %0d required %0d", $time, count, exp_q.size());
        end
        model_ready = !rst && (exp_q.size() < DEPTH);
        checks++;
        if (req_ready !== model_ready) begin
            errors++;
            $display("FAIL req_ready t=%0t got %b required %b", $time, req_ready, model_ready);
        end
        issue_rd = 1'b0;
        if (exp_cs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (gp_we_l !== ~e.wr || gp_addr !== e.addr || (e.wr && gp_wdata !== e.data)) begin
                errors++;
                $display("FAIL bus_txn t=%0t got we_l=%b addr=%h wdata=%h required we_l=%b addr=%h wdata=%h",
                         $time, gp_we_l, gp_addr, gp_wdata, ~e.wr, e.addr, e.data);
            end
            if (e.wr) begin
                ref_ram[e.addr] = e.data;
            end else begin
                rsp_exp_q.push_back(ref_ram[e.addr]);
                issue_rd = 1'b1;
            end
        end
        prev_idle = !exp_cs && !rd_d1;
        rd_d2     = rd_d1;
        rd_d1     = issue_rd;
        prev_size = exp_q.size();
        if (req_valid && model_ready) begin
            e.wr   = req_write;
            e.addr = req_addr;
            e.data = req_data;
            exp_q.push_back(e);
        end
        prev_gate = GATED ? vblank : 1'b1;
        if (rst) begin
            exp_q.delete();
            rsp_exp_q.delete();
            rd_d1    = 1'b0;
            rd_d2    = 1'b0;
            last_rsp = 8'h00;
        end
        prev_rst = rst;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until an edge accepts it; returns 1 ns after that edge.
    task automatic push(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            done = (req_ready === 1'b1);
            tick();
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout addr=%h got no req_ready required req_ready=1", a);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (gp_cs_l !== 1'b1 || gp_we_l !== 1'b1) begin
            errors++;
            $display("FAIL reset_cs_we got cs_l=%b we_l=%b required 1 1", gp_cs_l, gp_we_l);
        end
        checks++;
        if (gp_addr !== '0 || gp_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr_data got %h %h required 0 0", gp_addr, gp_wdata);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp got %b %h required 0 00", rsp_valid, rsp_data);
        end
        checks++;
        if (count !== '0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_ready got %0d %b required 0 0", count, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", req_ready);
        end
        tick();
    endtask

    task automatic test_single_write();
        vblank = 1'b1;
        push(1'b1, 16'h0123, 8'hA5);
        tick();
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b0 || gp_addr !== 16'h0123 || gp_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL single_write_bus got cs_l=%b we_l=%b addr=%h wdata=%h required 0 0 0123 a5",
                     gp_cs_l, gp_we_l, gp_addr, gp_wdata);
        end
        tick();
        checks++;
        if (gp_cs_l !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL single_write_end got cs_l=%b count=%0d required 1 0", gp_cs_l, count);
        end
        tick();
    endtask

    task automatic test_read();
        vblank = 1'b1;
        push(1'b0, 16'h0040, 8'h00);
        tick();
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b1 || gp_addr !== 16'h0040) begin
            errors++;
            $display("FAIL read_select got cs_l=%b we_l=%b addr=%h required 0 1 0040",
                     gp_cs_l, gp_we_l, gp_addr);
        end
        tick();
        checks++;
        if (gp_cs_l !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_wait got cs_l=%b rsp_valid=%b required 1 0", gp_cs_l, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_rsp got valid=%b data=%h required 1 3c", rsp_valid, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_rsp_hold got valid=%b data=%h required 0 3c", rsp_valid, rsp_data);
        end
    endtask

    // Write then read to the same address on consecutive edges: selects at E+1 and E+3.
    task automatic test_back_to_back();
        vblank    = GATED;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0200;
        req_data  = 8'h11;
        tick();
        req_write = 1'b0;
        checks++;
        if (gp_cs_l !== 1'b1) begin
            errors++;
            $display("FAIL b2b_e0 got cs_l=%b required 1", gp_cs_l);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b0 || gp_addr !== 16'h0200) begin
            errors++;
            $display("FAIL b2b_write got cs_l=%b we_l=%b addr=%h required 0 0 0200",
                     gp_cs_l, gp_we_l, gp_addr);
        end
        tick();
        checks++;
        if (gp_cs_l !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got cs_l=%b required 1", gp_cs_l);
        end
        tick();
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b1 || gp_addr !== 16'h0200) begin
            errors++;
            $display("FAIL b2b_read got cs_l=%b we_l=%b addr=%h required 0 1 0200",
                     gp_cs_l, gp_we_l, gp_addr);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
            errors++;
            $display("FAIL b2b_rsp got valid=%b data=%h required 1 11", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_fill_stream();
        bit saw_full = 1'b0;
        vblank = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(1'b1, 16'h2000 + 16'(i), 8'(i));
            if (count === CW'(DEPTH)) begin
                saw_full = 1'b1;
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_full_ready got %b required 0", req_ready);
                end
            end
        end
        checks++;
        if (!saw_full) begin
            errors++;
            $display("FAIL stream_fill got no full queue required count=%0d", DEPTH);
        end
        for (int i = 0; i < 100 && count !== '0; i++) tick();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL stream_drain got count=%0d required 0", count);
        end
        tick();
    endtask

`ifdef VBLANK_GATE_EN
    task automatic test_fill_gated();
        int n    = 0;
        int last = 0;
        vblank = 1'b0;
        for (int i = 0; i < 16; i++) push(1'b1, 16'h1000 + 16'(i), 8'(i * 7 + 3));
        checks++;
        if (count !== CW'(16) || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got count=%0d ready=%b required 16 0", count, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h1FFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== CW'(16) || gp_cs_l !== 1'b1) begin
                errors++;
                $display("FAIL fill_blocked got count=%0d cs_l=%b required 16 1", count, gp_cs_l);
            end
        end
        req_valid = 1'b0;
        vblank    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gp_cs_l === 1'b0) begin
                checks++;
                if (gp_addr !== 16'h1000 + 16'(n) || (n > 0 && i - last != 2)) begin
                    errors++;
                    $display("FAIL fill_drain_order got addr=%h gap=%0d required addr=%h gap=2",
                             gp_addr, i - last, 16'h1000 + 16'(n));
                end
                last = i;
                n++;
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL fill_drain_count got %0d selects required 16", n);
        end
    endtask

    task automatic test_vblank_fall();
        vblank = 1'b0;
        push(1'b0, 16'h0041, 8'h00);
        push(1'b1, 16'h0300, 8'h77);
        tick();
        vblank = 1'b1;
        tick();
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b1 || gp_addr !== 16'h0041) begin
            errors++;
            $display("FAIL vfall_select got cs_l=%b we_l=%b addr=%h required 0 1 0041",
                     gp_cs_l, gp_we_l, gp_addr);
        end
        vblank = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== init_val(16'h0041)) begin
            errors++;
            $display("FAIL vfall_rsp got valid=%b data=%h required 1 %h",
                     rsp_valid, rsp_data, init_val(16'h0041));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gp_cs_l !== 1'b1 || count !== CW'(1)) begin
                errors++;
                $display("FAIL vfall_wait got cs_l=%b count=%0d required 1 1", gp_cs_l, count);
            end
        end
        vblank = 1'b1;
        tick();
        checks++;
        if (gp_cs_l !== 1'b0 || gp_we_l !== 1'b0 || gp_addr !== 16'h0300) begin
            errors++;
            $display("FAIL vfall_next got cs_l=%b we_l=%b addr=%h required 0 0 0300",
                     gp_cs_l, gp_we_l, gp_addr);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        bit found = 1'b0;
        vblank = 1'b1;
        push(1'b1, 16'h0400, 8'h01);
        push(1'b1, 16'h0401, 8'h02);
        push(1'b0, 16'h0040, 8'h00);
        push(1'b1, 16'h0402, 8'h03);
        push(1'b1, 16'h0403, 8'h04);
        push(1'b1, 16'h0404, 8'h05);
        for (int i = 0; i < 20 && !found; i++) begin
            if (gp_cs_l === 1'b0 && gp_we_l === 1'b1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_read got no read select required one");
        end
        tick();
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL rstmid_queued got count=%0d required 3", count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready got %b required 0", req_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (count !== '0 || gp_cs_l !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got count=%0d cs_l=%b rsp_valid=%b required 0 1 0",
                     count, gp_cs_l, rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gp_cs_l !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet got cs_l=%b rsp_valid=%b required 1 0", gp_cs_l, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid = ($urandom_range(0, 99) < 55);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 16'h0100 + 16'($urandom_range(0, 15));
            req_data  = 8'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) vblank = ~vblank;
            tick();
        end
        req_valid = 1'b0;
        rst       = 1'b0;
        vblank    = 1'b1;
        for (int i = 0; i < 200 && count !== '0; i++) tick();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL random_drain got count=%0d required 0", count);
        end
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
`ifdef VBLANK_GATE_EN
        test_fill_gated();
        test_vblank_fall();
`endif
        test_fill_stream();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
